// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage pipelined IEEE-754 compare / min-max unit.
// Operations are FEQ, FLT, FLE, FMIN and FMAX, at 32- or 64-bit width.
// The unit generates RISC-V style invalid (NV) flags and keeps a sticky NV accumulator.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both high.
// Stage 2 is free when it is empty or its result is being taken (s2_free = ~out_valid | out_ready).
// in_ready = ~s1_valid | s2_free depends only on state and out_ready, never on in_valid.
// While out_valid=1 and out_ready=0 every out_* port holds its value.
// Accepting a new operation and draining a result in the same cycle is allowed and leaves no bubble.
module fp_compare_pipe #(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [BUS_WIDTH-1:0] in_a,
  input  logic [BUS_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_result,
  output logic                 out_nv,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 nv_sticky,
  input  logic                 nv_clr
);

  localparam int MANT = (BUS_WIDTH == 64) ? 52 : 23;
  localparam int EXP  = (BUS_WIDTH == 64) ? 11 : 8;
  localparam logic [BUS_WIDTH-1:0] CANON_NAN = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT-1){1'b0}}};

  localparam logic [2:0] OP_FEQ  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FLE  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;

  logic s2_free;

  // Operand classification of the incoming pair, registered into stage 1
  logic a_nan_c, a_snan_c, a_zero_c, b_nan_c, b_snan_c, b_zero_c, mag_lt_c, bit_eq_c;

  assign a_nan_c  = (&in_a[BUS_WIDTH-2 -: EXP]) & (|in_a[MANT-1:0]);
  assign a_snan_c = a_nan_c & ~in_a[MANT-1];
  assign a_zero_c = ~|in_a[BUS_WIDTH-2:0];
  assign b_nan_c  = (&in_b[BUS_WIDTH-2 -: EXP]) & (|in_b[MANT-1:0]);
  assign b_snan_c = b_nan_c & ~in_b[MANT-1];
  assign b_zero_c = ~|in_b[BUS_WIDTH-2:0];
  assign mag_lt_c = in_a[BUS_WIDTH-2:0] < in_b[BUS_WIDTH-2:0];
  assign bit_eq_c = in_a == in_b;

  logic                 s1_valid;
  logic [2:0]           s1_op;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [BUS_WIDTH-1:0] s1_a, s1_b;
  logic                 s1_a_nan, s1_a_snan, s1_a_zero;
  logic                 s1_b_nan, s1_b_snan, s1_b_zero;
  logic                 s1_mag_lt, s1_bit_eq;

  assign s2_free  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_free;

  // Stage 1: capture the operation and its operand classes when the stage can advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_tag    <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_nan  <= 1'b0;
      s1_a_snan <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_b_snan <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_mag_lt <= 1'b0;
      s1_bit_eq <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op     <= in_op;
        s1_tag    <= in_tag;
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_a_nan  <= a_nan_c;
        s1_a_snan <= a_snan_c;
        s1_a_zero <= a_zero_c;
        s1_b_nan  <= b_nan_c;
        s1_b_snan <= b_snan_c;
        s1_b_zero <= b_zero_c;
        s1_mag_lt <= mag_lt_c;
        s1_bit_eq <= bit_eq_c;
      end
    end
  end

  // Sign/magnitude ordering: lt_mm treats -0 < +0 (min/max), lt/eq treat the zeros as equal
  logic a_sign, b_sign, any_nan, any_snan, both_zero, lt_mm, lt, eq;

  assign a_sign    = s1_a[BUS_WIDTH-1];
  assign b_sign    = s1_b[BUS_WIDTH-1];
  assign any_nan   = s1_a_nan | s1_b_nan;
  assign any_snan  = s1_a_snan | s1_b_snan;
  assign both_zero = s1_a_zero & s1_b_zero;
  assign lt_mm     = (a_sign != b_sign) ? a_sign :
                     (!a_sign)          ? s1_mag_lt : (~s1_mag_lt & ~s1_bit_eq);
  assign lt        = lt_mm & ~both_zero;
  assign eq        = s1_bit_eq | both_zero;

  logic [BUS_WIDTH-1:0] res_c;
  logic                 nv_c;

  // Final result and NV flag for the operation held in stage 1
  always_comb begin
    res_c = '0;
    nv_c  = 1'b0;
    case (s1_op)
      OP_FEQ: begin
        res_c[0] = ~any_nan & eq;
        nv_c     = any_snan;
      end
      OP_FLT: begin
        res_c[0] = ~any_nan & lt;
        nv_c     = any_nan;
      end
      OP_FLE: begin
        res_c[0] = ~any_nan & (lt | eq);
        nv_c     = any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        nv_c = any_snan;
        if (s1_a_nan && s1_b_nan)   res_c = CANON_NAN;
        else if (s1_a_nan)          res_c = s1_b;
        else if (s1_b_nan)          res_c = s1_a;
        else if (s1_op == OP_FMIN)  res_c = lt_mm ? s1_a : s1_b;
        else                        res_c = lt_mm ? s1_b : s1_a;
      end
      default: begin
        res_c = '0;
        nv_c  = 1'b0;
      end
    endcase
  end

  // Stage 2: output register, advances only when empty or being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_nv     <= 1'b0;
      out_tag    <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_c;
        out_nv     <= nv_c;
        out_tag    <= s1_tag;
      end
    end
  end

  // Sticky NV: set by any delivered result with NV, clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               nv_sticky <= 1'b0;
    else if (nv_clr)                          nv_sticky <= 1'b0;
    else if (out_valid && out_ready && out_nv) nv_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: directed vector bench for fp_compare_pipe at BUS_WIDTH=32.
module tb_fp_compare_pipe;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_nv;
  logic [TW-1:0] out_tag;
  logic          nv_sticky;
  logic          nv_clr;

  fp_compare_pipe #(.BUS_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nv(out_nv), .out_tag(out_tag),
    .nv_sticky(nv_sticky), .nv_clr(nv_clr)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         nv;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  // Scoreboard for the streamed (backpressure) section: {tag, result}
  logic [TW+W-1:0] exp_q[$];
  logic            mon_en = 1'b0;
  int              recv_cnt = 0;
  int              last_xfer = -1;

  // Monitor: at the negedge, a valid&ready pair transfers on the next rising edge
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 64'(out_result), 64'hDEAD);
      end else begin
        logic [TW+W-1:0] e;
        e = exp_q.pop_front();
        check("sb_result", 64'(out_result), 64'(e[W-1:0]));
        check("sb_tag", 64'(out_tag), 64'(e[TW+W-1:W]));
        if (recv_cnt > 0) check("sb_gap", 64'(cyc - last_xfer), 64'd1);
      end
      last_xfer = cyc;
      recv_cnt++;
    end
  end

  // Driver: offer one operation, wait (bounded) for acceptance
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  // Single operation with latency check; optionally pulse nv_clr on the drain edge
  task automatic apply_vec(input vec_t v, input logic [TW-1:0] tag, input bit clr_on_drain);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = v.op; in_a = v.a; in_b = v.b; in_tag = tag;
    check("vec_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("vec_lat1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("vec_lat2_valid", 64'(out_valid), 64'd1);
    check("vec_result", 64'(out_result), 64'(v.res));
    check("vec_nv", 64'(out_nv), 64'(v.nv));
    check("vec_tag", 64'(out_tag), 64'(tag));
    if (clr_on_drain) nv_clr = 1'b1;
    @(posedge clk); #1;
    nv_clr = 1'b0;
  endtask

  initial begin
    // Vector table: op, a, b, expected result, expected nv
    vecs[0]  = '{3'd2, 32'h3F800000, 32'h40000000, 32'h00000001, 1'b0}; // FLE 1<=2
    vecs[1]  = '{3'd0, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0}; // FEQ -0==+0
    vecs[2]  = '{3'd3, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0}; // FMIN -0,+0
    vecs[3]  = '{3'd4, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0}; // FMAX -0,+0
    vecs[4]  = '{3'd1, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1}; // FLT qNaN
    vecs[5]  = '{3'd0, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0}; // FEQ qNaN
    vecs[6]  = '{3'd0, 32'h7F800001, 32'h3F800000, 32'h00000000, 1'b1}; // FEQ sNaN
    vecs[7]  = '{3'd4, 32'h7F800001, 32'hC0000000, 32'hC0000000, 1'b1}; // FMAX sNaN,-2
    vecs[8]  = '{3'd4, 32'h7FC00000, 32'h7F800001, 32'h7FC00000, 1'b1}; // FMAX both NaN
    vecs[9]  = '{3'd1, 32'hBF800000, 32'h3F800000, 32'h00000001, 1'b0}; // FLT -1<1
    vecs[10] = '{3'd1, 32'hC0000000, 32'hBF800000, 32'h00000001, 1'b0}; // FLT -2<-1
    vecs[11] = '{3'd2, 32'hBF800000, 32'hBF800000, 32'h00000001, 1'b0}; // FLE equal
    vecs[12] = '{3'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0}; // FLT equal
    vecs[13] = '{3'd3, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0}; // FMIN 2,1
    vecs[14] = '{3'd4, 32'hFF800000, 32'h7F800000, 32'h7F800000, 1'b0}; // FMAX -inf,+inf
    vecs[15] = '{3'd1, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0}; // FLT subnormals
    vecs[16] = '{3'd5, 32'h3F800000, 32'h7F800001, 32'h00000000, 1'b0}; // reserved op
    vecs[17] = '{3'd3, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0}; // FMIN qNaN,qNaN
    vecs[18] = '{3'd2, 32'h00000000, 32'h80000000, 32'h00000001, 1'b0}; // FLE +0<=-0
    vecs[19] = '{3'd1, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0}; // FLT +0<-0

    // Reset block
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1; nv_clr = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_nv", 64'(out_nv), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_nv_sticky", 64'(nv_sticky), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) apply_vec(vecs[i], TW'(i + 3), 1'b0);

    // Sticky: table contained NV results, then clear
    check("sticky_set", 64'(nv_sticky), 64'd1);
    nv_clr = 1'b1;
    @(posedge clk); #1;
    nv_clr = 1'b0;
    check("sticky_cleared", 64'(nv_sticky), 64'd0);
    apply_vec(vecs[0], 5'd9, 1'b0);
    check("sticky_stays_clear", 64'(nv_sticky), 64'd0);
    apply_vec(vecs[4], 5'd10, 1'b0);
    check("sticky_set_again", 64'(nv_sticky), 64'd1);
    nv_clr = 1'b1;
    @(posedge clk); #1;
    nv_clr = 1'b0;
    apply_vec(vecs[6], 5'd11, 1'b1);
    check("sticky_clr_priority", 64'(nv_sticky), 64'd0);

    // Backpressure: 4 ops with out_ready low
    out_ready = 1'b0;
    mon_en = 1'b1;
    recv_cnt = 0;
    exp_q.push_back({5'd1, 32'h00000001});
    send(3'd2, 32'h3F800000, 32'h40000000, 5'd1);
    exp_q.push_back({5'd2, 32'h3F800000});
    send(3'd3, 32'h40000000, 32'h3F800000, 5'd2);
    in_valid = 1'b1; in_op = 3'd1; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 5'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(out_result), 64'h00000001);
      check("bp_hold_tag", 64'(out_tag), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back({5'd3, 32'h00000001});
    send(3'd1, 32'h3F800000, 32'h40000000, 5'd3);
    exp_q.push_back({5'd4, 32'hBF800000});
    send(3'd4, 32'hC0000000, 32'hBF800000, 5'd4);
    for (int k = 0; k < 20 && recv_cnt < 4; k++) @(posedge clk);
    #1;
    check("bp_recv_count", 64'(recv_cnt), 64'd4);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    // Mid-stream asynchronous reset
    out_ready = 1'b0;
    send(3'd1, 32'h7FC00000, 32'h3F800000, 5'd7);
    send(3'd2, 32'h3F800000, 32'h40000000, 5'd8);
    #2;
    check("mid_valid_before_rst", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      check("mid_no_stale", 64'(stale), 64'd0);
    end
    check("mid_in_ready_after", 64'(in_ready), 64'd1);
    check("mid_sticky_after", 64'(nv_sticky), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Pipelined IEEE-754 compare / min-max unit for the FPU; successor to the combinational single-op greater-or-equal comparator.
- Supports FEQ, FLT, FLE, FMIN and FMAX at 32- or 64-bit width.
- Has valid/ready handshakes, tag pass-through, RISC-V-style invalid (NV) flag generation and a sticky NV accumulator.
- Sits between the FP issue logic and writeback.

Parameters:
- BUS_WIDTH, 64, operand width; legal values 32 or 64. Derived: MANT = 52/23, EXP = 11/8.
- TAG_WIDTH, 5, width of the destination tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit accepts the operation this cycle
- in_op  input  3  operation: 000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX; 101-111 reserved
- in_a  input  BUS_WIDTH  operand 1
- in_b  input  BUS_WIDTH  operand 2
- in_tag  input  TAG_WIDTH  tag
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_result  output  BUS_WIDTH  compare ops: 0 or 1, zero-extended; min/max ops: selected value
- out_nv  output  1  invalid-operation flag for this result
- out_tag  output  TAG_WIDTH  tag of this result
- nv_sticky  output  1  OR of every out_nv delivered since the last clear
- nv_clr  input  1  clears nv_sticky synchronously

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids, out_valid, out_result, out_nv, out_tag and nv_sticky go to 0. in_ready is 1 after reset. Any operation in flight when reset asserts is discarded.
- Pipeline has 2 register stages.
  - S1 captures the operation and pre-computes per-operand class: NaN, sNaN (EXP all ones, MANT nonzero, MANT msb 0), zero, sign, plus magnitude-less-than and bit-equal.
  - S2 holds the final result and drives the out_* ports.
- Latency is 2 cycles from an accepted input to out_valid with no backpressure. Throughput is 1 operation per cycle.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - s2_free = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | s2_free.
  - in_ready must not depend combinationally on in_valid.
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - Simultaneous accept and drain on the same cycle is legal and produces no bubble.
- Ordering rules:
  - -0 and +0 compare equal.
  - For FMIN/FMAX, -0 is treated as less than +0.
  - Otherwise ordering follows sign/magnitude.
- FEQ: result 1 iff a == b under the rule above; 0 if either operand is NaN. NV is set only if either operand is sNaN.
- FLT/FLE: result is a<b or a<=b respectively; 0 if either operand is NaN. NV is set if either operand is any NaN (qNaN or sNaN).
- FMIN/FMAX:
  - If exactly one operand is NaN, return the other operand.
  - If both are NaN, return the canonical NaN: 32'h7FC00000 or 64'h7FF8000000000000.
  - NV is set if either operand is sNaN.
- Reserved ops: result 0, NV 0; the tag is still returned.
- nv_sticky is set on any output transfer with out_nv=1.
  - nv_clr has priority over a same-cycle set: result is 0 for that cycle's update.
  - The flag from that same transfer is lost. This is intended; software clears only while the unit is idle.
- Infinities compare normally. Subnormals compare by raw bits; no flushing.

Test Plan (BUS_WIDTH=32):
- FLE a=3F800000 (1.0), b=40000000 (2.0), out_ready=1 held high → out_valid exactly 2 cycles after accept; result=1, nv=0, tag echoed.
- FEQ a=80000000 (-0), b=00000000 (+0) → result 1. FMIN on the same pair → 80000000. FMAX on the same pair → 00000000.
- FLT a=7FC00000 (qNaN), b=3F800000 → result 0, nv=1. FEQ on the same pair → nv=0. FEQ a=7F800001 (sNaN) → nv=1.
- FMAX a=7F800001, b=C0000000 → result C0000000, nv=1. FMAX a=7FC00000, b=7F800001 → result 7FC00000, nv=1.
- Backpressure: issue 4 back-to-back ops with out_ready=0.
  - in_ready falls after 2 accepted ops; outputs stay stable.
  - Raise out_ready → all 4 results arrive in order, no loss or duplication, 1 per cycle.
- Sticky and reset:
  - An nv=1 result sets nv_sticky.
  - Pulsing nv_clr clears it.
  - Asserting rst_n=0 mid-stream drops out_valid immediately, asynchronously; after release, in_ready=1 and no stale result appears.
